// File: rtl/bus_wait_ctrl_if.sv
// ----------------------------------------------------------------------------
// bus_wait_ctrl_if
//   Bundles the CPU-side access signals and the per-channel peripheral
//   handshake of bus_wait_ctrl. Signal names keep the controller's point of
//   view (_i = into the controller, _o = out of it).
//
//   modport slave  : used by bus_wait_ctrl (serves the CPU, drives channels)
//   modport master : used by the environment (CPU decode + peripherals)
//
//   CPU side    : cpu_valid_i, cpu_we_i, cpu_address_i, cpu_data_i,
//                 cpu_data_o, busy_o
//   Channel side: ch_req_o, ch_we_o, ch_address_o, ch_data_o,
//                 ch_ack_i, ch_data_i
//   Watchdog    : timeout_o, timeout_count_o
// ----------------------------------------------------------------------------
interface bus_wait_ctrl_if #(
    parameter int unsigned NumChannels  = 4,
    parameter int unsigned AddressWidth = 32,
    parameter int unsigned DataWidth    = 32
);
    logic                            cpu_valid_i;
    logic                            cpu_we_i;
    logic [AddressWidth-1:0]         cpu_address_i;
    logic [DataWidth-1:0]            cpu_data_i;
    logic [DataWidth-1:0]            cpu_data_o;
    logic                            busy_o;

    logic [NumChannels-1:0]          ch_req_o;
    logic                            ch_we_o;
    logic [AddressWidth-1:0]         ch_address_o;
    logic [DataWidth-1:0]            ch_data_o;
    logic [NumChannels-1:0]          ch_ack_i;
    logic [NumChannels*DataWidth-1:0] ch_data_i;

    logic                            timeout_o;
    logic [7:0]                      timeout_count_o;

    modport slave (
        input  cpu_valid_i, cpu_we_i, cpu_address_i, cpu_data_i,
        input  ch_ack_i, ch_data_i,
        output cpu_data_o, busy_o,
        output ch_req_o, ch_we_o, ch_address_o, ch_data_o,
        output timeout_o, timeout_count_o
    );

    modport master (
        output cpu_valid_i, cpu_we_i, cpu_address_i, cpu_data_i,
        output ch_ack_i, ch_data_i,
        input  cpu_data_o, busy_o,
        input  ch_req_o, ch_we_o, ch_address_o, ch_data_o,
        input  timeout_o, timeout_count_o
    );
endinterface

// File: rtl/bus_wait_ctrl.sv
// ----------------------------------------------------------------------------
// bus_wait_ctrl
//   Stalls the CPU while one of NumChannels address-windowed peripherals
//   completes a request/acknowledge handshake. A hit latches the access,
//   pulses the channel request, waits for that channel's ack, and returns
//   registered read data for one RESP cycle. Misses are ignored.
//
//   Ports:
//     clk_i      : CPU clock
//     reset_n_i  : asynchronous active-low reset
//     bus        : bus_wait_ctrl_if.slave (CPU access, channel handshake,
//                  watchdog status)
//
//   Optional feature: define BUS_WAIT_TIMEOUT_EN to enable the WAIT-state
//   watchdog (timeout_o pulse, saturating timeout_count_o). Without it WAIT
//   only exits on ack and both watchdog outputs are tied to 0.
// ----------------------------------------------------------------------------
module bus_wait_ctrl #(
    parameter int unsigned                         NumChannels   = 4,
    parameter int unsigned                         AddressWidth  = 32,
    parameter int unsigned                         DataWidth     = 32,
    parameter logic [NumChannels*AddressWidth-1:0] ChStartAddr   = '0,
    parameter logic [NumChannels*AddressWidth-1:0] ChEndAddr     = '0,
    parameter int unsigned                         TimeoutCycles = 256,
    parameter logic [DataWidth-1:0]                TimeoutData   = 32'hDEADBEEF
) (
    input  logic           clk_i,
    input  logic           reset_n_i,
    bus_wait_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_e;

    state_e                  state_q, state_d;
    logic [NumChannels-1:0]  hit_vec;
    logic                    hit;
    logic [NumChannels-1:0]  sel_q;
    logic                    we_q;
    logic [AddressWidth-1:0] addr_q;
    logic [DataWidth-1:0]    wdata_q;
    logic [DataWidth-1:0]    rdata_q;
    logic [DataWidth-1:0]    ack_data;
    logic                    sel_ack;
    logic                    timeout_fire;

    // Window decode; the first matching (lowest) index wins on overlap.
    always_comb begin
        hit_vec = '0;
        hit     = 1'b0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            if (!hit &&
                bus.cpu_address_i >= ChStartAddr[i*AddressWidth +: AddressWidth] &&
                bus.cpu_address_i <= ChEndAddr[i*AddressWidth +: AddressWidth]) begin
                hit_vec[i] = 1'b1;
                hit        = 1'b1;
            end
        end
    end

    // Only the selected channel's ack and data are observed.
    assign sel_ack = |(bus.ch_ack_i & sel_q);

    always_comb begin
        ack_data = '0;
        for (int unsigned i = 0; i < NumChannels; i++) begin
            if (sel_q[i]) begin
                ack_data = bus.ch_data_i[i*DataWidth +: DataWidth];
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        bus.busy_o       = 1'b0;
        bus.ch_req_o     = '0;
        bus.cpu_data_o   = '0;
        bus.ch_we_o      = 1'b0;
        bus.ch_address_o = '0;
        bus.ch_data_o    = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.cpu_valid_i && hit) begin
                    bus.busy_o = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                bus.busy_o   = 1'b1;
                bus.ch_req_o = sel_q;
                state_d      = sel_ack ? RESP : WAIT;
            end
            WAIT: begin
                bus.busy_o = 1'b1;
                if (sel_ack || timeout_fire) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.cpu_data_o = rdata_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (state_q != IDLE) begin
            bus.ch_we_o      = we_q;
            bus.ch_address_o = addr_q;
            bus.ch_data_o    = wdata_q;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            sel_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state_q == IDLE && state_d == REQ) begin
                sel_q   <= hit_vec;
                we_q    <= bus.cpu_we_i;
                addr_q  <= bus.cpu_address_i;
                wdata_q <= bus.cpu_data_i;
            end
            // Ack takes priority over a simultaneous watchdog abort.
            if ((state_q == REQ || state_q == WAIT) && state_d == RESP) begin
                rdata_q <= we_q ? '0 : (sel_ack ? ack_data : TimeoutData);
            end
        end
    end

`ifdef BUS_WAIT_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TimeoutCycles + 1);

    logic [CntW-1:0] wait_cnt_q;
    logic            timeout_q;
    logic [7:0]      timeout_count_q;

    assign timeout_fire = (state_q == WAIT) && !sel_ack &&
                          (wait_cnt_q == CntW'(TimeoutCycles - 1));

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wait_cnt_q      <= '0;
            timeout_q       <= 1'b0;
            timeout_count_q <= '0;
        end else begin
            if (state_q == IDLE && state_d == REQ) begin
                wait_cnt_q <= '0;
            end else if (state_q == WAIT) begin
                wait_cnt_q <= wait_cnt_q + CntW'(1);
            end
            // An abort always moves to RESP, so the registered flag lines up
            // with the RESP cycle.
            timeout_q <= timeout_fire;
            if (timeout_fire && timeout_count_q != 8'hFF) begin
                timeout_count_q <= timeout_count_q + 8'd1;
            end
        end
    end

    assign bus.timeout_o       = timeout_q;
    assign bus.timeout_count_o = timeout_count_q;
`else
    assign timeout_fire        = 1'b0;
    assign bus.timeout_o       = 1'b0;
    assign bus.timeout_count_o = '0;
`endif

endmodule

// File: tb/tb_bus_wait_ctrl.sv
// ----------------------------------------------------------------------------
// tb_bus_wait_ctrl
//   Directed and randomized accesses against a transaction-level model:
//   per access the model derives the response cycle, expected read data and
//   watchdog outcome from the window table and ack timing, then every output
//   is compared each cycle at the falling edge.
// ----------------------------------------------------------------------------
module tb_bus_wait_ctrl;

    localparam int unsigned NCh = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned TO  = 8;
    localparam logic [31:0] DEAD = 32'hDEADBEEF;

`ifdef BUS_WAIT_TIMEOUT_EN
    localparam bit TimeoutEn = 1'b1;
`else
    localparam bit TimeoutEn = 1'b0;
`endif

    // Window table used by the model (ch2/ch3 overlap at 0x280-0x2FF).
    localparam int unsigned WinLo [NCh] = '{32'h000, 32'h100, 32'h200, 32'h280};
    localparam int unsigned WinHi [NCh] = '{32'h0FF, 32'h1FF, 32'h2FF, 32'h3FF};

    logic clk;
    logic rst_n;

    int unsigned tests;
    int unsigned fails;
    int unsigned tcount;

    bus_wait_ctrl_if #(.NumChannels(NCh), .AddressWidth(AW), .DataWidth(DW)) bus ();

    bus_wait_ctrl #(
        .NumChannels  (NCh),
        .AddressWidth (AW),
        .DataWidth    (DW),
        .ChStartAddr  ({32'h280, 32'h200, 32'h100, 32'h000}),
        .ChEndAddr    ({32'h3FF, 32'h2FF, 32'h1FF, 32'h0FF}),
        .TimeoutCycles(TO),
        .TimeoutData  (DEAD)
    ) dut (
        .clk_i    (clk),
        .reset_n_i(rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  64'(bus.busy_o), 64'd0);
        check({tag, "_req"},   64'(bus.ch_req_o), 64'd0);
        check({tag, "_addr"},  64'(bus.ch_address_o), 64'd0);
        check({tag, "_wdata"}, 64'(bus.ch_data_o), 64'd0);
        check({tag, "_we"},    64'(bus.ch_we_o), 64'd0);
        check({tag, "_rdata"}, 64'(bus.cpu_data_o), 64'd0);
        check({tag, "_tout"},  64'(bus.timeout_o), 64'd0);
    endtask

    function automatic int find_ch(input logic [31:0] a);
        for (int i = 0; i < int'(NCh); i++) begin
            if (a >= WinLo[i] && a <= WinHi[i]) return i;
        end
        return -1;
    endfunction

    // One CPU access. ack_at is the cycle (strobe = cycle 0) at which the
    // selected channel acks; distract adds random acks on other channels.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input int unsigned ack_at, input logic [31:0] rdata, input bit distract);
        int          ch;
        bit          hit;
        bit          tmo;
        int unsigned resp;
        logic [3:0]  oh;
        logic [31:0] exp_rd;
        int unsigned tc_old;
        int unsigned tc_new;
        ch     = find_ch(addr);
        hit    = (ch >= 0);
        oh     = hit ? 4'(1 << ch) : 4'b0;
        tmo    = TimeoutEn && hit && (ack_at > TO + 1);
        resp   = hit ? ((tmo ? TO + 1 : ack_at) + 1) : 0;
        exp_rd = we ? 32'd0 : (tmo ? DEAD : rdata);
        tc_old = tcount;
        if (tmo && tcount < 255) tcount++;
        tc_new = tcount;
        for (int unsigned c = 0; c <= resp + 1; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                bus.cpu_valid_i   = 1'b1;
                bus.cpu_we_i      = we;
                bus.cpu_address_i = addr;
                bus.cpu_data_i    = wdata;
            end else begin
                // Strobes while stalled (or in RESP) must be ignored.
                bus.cpu_valid_i   = (c <= resp) ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.cpu_we_i      = 1'($urandom_range(0, 1));
                bus.cpu_address_i = 32'($urandom_range(0, 32'h3FF));
                bus.cpu_data_i    = $urandom;
            end
            bus.ch_data_i = {$urandom, $urandom, $urandom, $urandom};
            bus.ch_ack_i  = '0;
            if (distract && c >= 1) bus.ch_ack_i = 4'($urandom) & ~oh;
            if (hit && c == ack_at) begin
                bus.ch_ack_i = bus.ch_ack_i | oh;
                bus.ch_data_i[ch*32 +: 32] = rdata;
            end
            @(negedge clk);
            check($sformatf("busy@%0d", c),  64'(bus.busy_o),   64'(hit && c < resp));
            check($sformatf("req@%0d", c),   64'(bus.ch_req_o), 64'((hit && c == 1) ? oh : 4'b0));
            check($sformatf("addr@%0d", c),  64'(bus.ch_address_o),
                  64'((hit && c >= 1 && c <= resp) ? addr : 32'd0));
            check($sformatf("wdata@%0d", c), 64'(bus.ch_data_o),
                  64'((hit && c >= 1 && c <= resp) ? wdata : 32'd0));
            check($sformatf("we@%0d", c),    64'(bus.ch_we_o),
                  64'(hit && c >= 1 && c <= resp && we));
            check($sformatf("rdata@%0d", c), 64'(bus.cpu_data_o),
                  64'((hit && c == resp) ? exp_rd : 32'd0));
            check($sformatf("tout@%0d", c),  64'(bus.timeout_o), 64'(tmo && c == resp));
            check($sformatf("tcnt@%0d", c),  64'(bus.timeout_count_o),
                  64'((tmo && c >= resp) ? tc_new : tc_old));
        end
        bus.ch_ack_i    = '0;
        bus.cpu_valid_i = 1'b0;
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        tcount = 0;
        rst_n  = 1'b0;
        bus.cpu_valid_i   = 1'b0;
        bus.cpu_we_i      = 1'b0;
        bus.cpu_address_i = '0;
        bus.cpu_data_i    = '0;
        bus.ch_ack_i      = '0;
        bus.ch_data_i     = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst");
        check("rst_tcnt", 64'(bus.timeout_count_o), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("post_rst");

        // Read ch1, ack at cycle 4
        access(1'b0, 32'h0000_0150, 32'h0, 4, 32'h1234_5678, 1'b0);
        // Write ch0, ack in REQ cycle (minimum access)
        access(1'b1, 32'h0000_0010, 32'hA5A5_0F0F, 1, 32'hFFFF_FFFF, 1'b0);
        // Miss: no stall, no request
        access(1'b0, 32'h0000_0900, 32'h0, 1, 32'h0, 1'b0);
        // Other-channel acks ignored while ch1 waits
        access(1'b0, 32'h0000_01F0, 32'h0, 6, 32'hCAFE_0001, 1'b1);
        // Overlap region: ch2 must win over ch3
        access(1'b0, 32'h0000_02A0, 32'h0, 2, 32'h0BAD_F00D, 1'b1);
        // Window edges
        access(1'b0, 32'h0000_03FF, 32'h0, 3, 32'h3333_3333, 1'b0);
        access(1'b1, 32'h0000_0200, 32'h7777_0000, 2, 32'h0, 1'b0);
        // Ack exactly when the watchdog would abort: ack wins
        access(1'b0, 32'h0000_0120, 32'h0, TO + 1, 32'h5555_AAAA, 1'b0);
        // No ack in time (timeout when enabled, otherwise a long wait)
        access(1'b0, 32'h0000_0130, 32'h0, 20, 32'h1111_2222, 1'b0);
        access(1'b1, 32'h0000_0030, 32'h9999_8888, 20, 32'h0, 1'b0);

        // Reset during WAIT
        @(posedge clk);
        #1;
        bus.cpu_valid_i   = 1'b1;
        bus.cpu_we_i      = 1'b0;
        bus.cpu_address_i = 32'h0000_0180;
        @(posedge clk);
        #1;
        bus.cpu_valid_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("rstw_busy_pre", 64'(bus.busy_o), 64'd1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rstw");
        check("rstw_tcnt", 64'(bus.timeout_count_o), 64'd0);
        tcount = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        bus.ch_ack_i = 4'b0010;
        bus.ch_data_i[63:32] = 32'hFEED_BEEF;
        @(negedge clk);
        check_idle_outputs("late_ack");
        @(posedge clk);
        #1;
        bus.ch_ack_i = '0;
        @(negedge clk);
        check_idle_outputs("late_ack_next");
        access(1'b0, 32'h0000_0100, 32'h0, 2, 32'h2468_ACE0, 1'b0);

        // Randomized accesses
        for (int n = 0; n < 40; n++) begin
            access(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h4FF)), $urandom,
                   $urandom_range(1, 12), $urandom, 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
